// File: rtl/alu_sequencer.sv
// alu_sequencer: programmable ALU sequencer. It holds a writable instruction
// memory and a register file, and it runs a programme of up to IMEM_DEPTH
// instructions. Each instruction takes two cycles, FETCH then EXEC.
//
// Instruction word, MSB to LSB: opcode[4] | ra[RID_W] | rb[RID_W] | imm[DATA_W]
//
// Ports
//   i_clock         system clock; all state changes on the rising edge
//   i_reset         synchronous active-high reset
//   i_imem_we       instruction memory write enable (honoured only in IDLE)
//   i_imem_addr     instruction memory write address
//   i_imem_wdata    instruction word to write
//   i_instr_count   number of valid instructions; latched when a run starts
//   i_start         run request (level or pulse; honoured only in IDLE)
//   i_rd_sel        register read-port select
//   o_rd_data       combinational read of register i_rd_sel
//   o_busy          high while in FETCH or EXEC
//   o_done          one-cycle pulse at the end of a run
//   o_aborted       sticky; set when the step limit ends a run
//   o_flag_z/c/gt   zero / carry(borrow) / unsigned-greater status flags
//
// state   | meaning
// S_IDLE  | waiting for start; the programme may be written
// S_FETCH | load the instruction register from imem[pc]
// S_EXEC  | execute the instruction, write back, update pc and steps
// S_DONE  | one-cycle done pulse, then return to IDLE
module alu_sequencer #(
   parameter int DATA_W     = 8,
   parameter int NREGS      = 8,
   parameter int IMEM_DEPTH = 16,
   parameter int MAX_STEPS  = 255
) (
   input  logic                                      i_clock,
   input  logic                                      i_reset,
   input  logic                                      i_imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0]             i_imem_addr,
   input  logic [4+2*$clog2(NREGS)+DATA_W-1:0]       i_imem_wdata,
   input  logic [$clog2(IMEM_DEPTH):0]               i_instr_count,
   input  logic                                      i_start,
   input  logic [$clog2(NREGS)-1:0]                  i_rd_sel,
   output logic [DATA_W-1:0]                         o_rd_data,
   output logic                                      o_busy,
   output logic                                      o_done,
   output logic                                      o_aborted,
   output logic                                      o_flag_z,
   output logic                                      o_flag_c,
   output logic                                      o_flag_gt
);

   localparam int RID_W   = $clog2(NREGS);
   localparam int PC_W    = $clog2(IMEM_DEPTH);
   localparam int INSTR_W = 4 + 2*RID_W + DATA_W;
   localparam int STEP_W  = $clog2(MAX_STEPS + 1);

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_NOT = 4'd2,  OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_INC = 4'd6,  OP_SHR = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8,  OP_CMP = 4'd9,  OP_LDI = 4'd10, OP_MOV = 4'd11;
   localparam logic [3:0] OP_BEQ = 4'd12, OP_BGT = 4'd13, OP_NOP = 4'd14, OP_HLT = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

   state_t                r_state, w_state_next;
   logic [INSTR_W-1:0]    r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]     r_regs [NREGS];
   logic [INSTR_W-1:0]    r_ir;
   logic [PC_W-1:0]       r_pc;
   logic [PC_W:0]         r_cnt;
   logic [STEP_W-1:0]     r_steps;
   logic                  r_aborted;
   logic                  r_flag_z, r_flag_c, r_flag_gt;

   logic [3:0]            w_op;
   logic [RID_W-1:0]      w_ra, w_rb;
   logic [DATA_W-1:0]     w_imm, w_a, w_b;
   logic [DATA_W:0]       w_wide;
   logic [DATA_W-1:0]     w_res;
   logic                  w_we, w_zupd, w_cupd, w_cval, w_cmp, w_taken, w_halt;
   logic [RID_W-1:0]      w_wsel;
   logic [PC_W:0]         w_pc_next;
   logic                  w_step_limit, w_exec_end;

   assign w_op  = r_ir[INSTR_W-1 -: 4];
   assign w_ra  = r_ir[DATA_W+2*RID_W-1 -: RID_W];
   assign w_rb  = r_ir[DATA_W+RID_W-1 -: RID_W];
   assign w_imm = r_ir[DATA_W-1:0];
   assign w_a   = r_regs[w_ra];
   assign w_b   = r_regs[w_rb];

   always_comb begin
      w_wide  = '0;
      w_res   = '0;
      w_we    = 1'b0;
      w_wsel  = w_ra;
      w_zupd  = 1'b0;
      w_cupd  = 1'b0;
      w_cval  = r_flag_c;
      w_cmp   = 1'b0;
      w_taken = 1'b0;
      w_halt  = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_wide = {1'b0, w_a} + {1'b0, w_b};
            w_res  = w_wide[DATA_W-1:0];
            w_cval = w_wide[DATA_W];
            w_cupd = 1'b1;
            w_we   = 1'b1;
         end
         OP_SUB: begin
            // the extra top bit of a widened subtract is the borrow
            w_wide = {1'b0, w_a} - {1'b0, w_b};
            w_res  = w_wide[DATA_W-1:0];
            w_cval = w_wide[DATA_W];
            w_cupd = 1'b1;
            w_we   = 1'b1;
         end
         OP_NOT: begin w_res = ~w_a;      w_we = 1'b1; end
         OP_AND: begin w_res = w_a & w_b; w_we = 1'b1; end
         OP_OR:  begin w_res = w_a | w_b; w_we = 1'b1; end
         OP_XOR: begin w_res = w_a ^ w_b; w_we = 1'b1; end
         OP_INC: begin
            w_wide = {1'b0, w_a} + {{DATA_W{1'b0}}, 1'b1};
            w_res  = w_wide[DATA_W-1:0];
            w_cval = w_wide[DATA_W];
            w_cupd = 1'b1;
            w_we   = 1'b1;
         end
         OP_SHR: begin
            w_res  = w_a >> 1;
            w_cval = w_a[0];
            w_cupd = 1'b1;
            w_we   = 1'b1;
         end
         OP_SHL: begin
            w_res  = w_a << 1;
            w_cval = w_a[DATA_W-1];
            w_cupd = 1'b1;
            w_we   = 1'b1;
         end
         OP_CMP: w_cmp = 1'b1;
         OP_LDI: begin w_res = w_imm; w_we = 1'b1; end
         OP_MOV: begin w_res = w_a; w_wsel = w_rb; w_we = 1'b1; end
         OP_BEQ: w_taken = r_flag_z;
         OP_BGT: w_taken = r_flag_gt;
         OP_HLT: w_halt  = 1'b1;
         default: ;
      endcase
      // every register-writing op except MOV drives the zero flag
      w_zupd = w_we && (w_op != OP_MOV);
   end

   // pc_next carries one extra bit so running off the end of a full memory
   // still compares correctly against the instruction count
   assign w_pc_next    = w_taken ? {1'b0, w_imm[PC_W-1:0]} : ({1'b0, r_pc} + 1'b1);
   assign w_step_limit = (r_steps + STEP_W'(1)) == STEP_W'(MAX_STEPS);
   assign w_exec_end   = w_halt || (w_pc_next >= r_cnt) || w_step_limit;

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = (i_instr_count == '0) ? S_DONE : S_FETCH;
         S_FETCH: w_state_next = S_EXEC;
         S_EXEC:  w_state_next = w_exec_end ? S_DONE : S_FETCH;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state == S_FETCH) || (r_state == S_EXEC);
      o_done = (r_state == S_DONE);
   end

   // programme storage survives reset
   always_ff @(posedge i_clock) begin
      if (i_imem_we && (r_state == S_IDLE)) r_imem[i_imem_addr] <= i_imem_wdata;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ir      <= '0;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_steps   <= '0;
         r_aborted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_cnt     <= i_instr_count;
               r_pc      <= '0;
               r_steps   <= '0;
               r_aborted <= 1'b0;
            end
            S_FETCH: r_ir <= r_imem[r_pc];
            S_EXEC: begin
               r_pc    <= w_pc_next[PC_W-1:0];
               r_steps <= r_steps + STEP_W'(1);
               if (w_step_limit) r_aborted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_flag_z  <= 1'b0;
         r_flag_c  <= 1'b0;
         r_flag_gt <= 1'b0;
      end else if (r_state == S_EXEC) begin
         if (w_we)   r_regs[w_wsel] <= w_res;
         if (w_zupd) r_flag_z <= (w_res == '0);
         if (w_cupd) r_flag_c <= w_cval;
         if (w_cmp) begin
            r_flag_z  <= (w_a == w_b);
            r_flag_gt <= (w_a > w_b);
         end
      end
   end

   assign o_rd_data = r_regs[i_rd_sel];
   assign o_aborted = r_aborted;
   assign o_flag_z  = r_flag_z;
   assign o_flag_c  = r_flag_c;
   assign o_flag_gt = r_flag_gt;

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

   localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  NOT = 4'd2,  AND = 4'd3;
   localparam logic [3:0] OR  = 4'd4,  XOR = 4'd5,  INC = 4'd6,  SHR = 4'd7;
   localparam logic [3:0] SHL = 4'd8,  CMP = 4'd9,  LDI = 4'd10, MOV = 4'd11;
   localparam logic [3:0] BEQ = 4'd12, BGT = 4'd13, NOP = 4'd14, HLT = 4'd15;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_imem_we = 1'b0;
   logic [3:0]  i_imem_addr = '0;
   logic [17:0] i_imem_wdata = '0;
   logic [4:0]  i_instr_count = '0;
   logic        i_start = 1'b0;
   logic [2:0]  i_rd_sel = '0;
   logic [7:0]  o_rd_data;
   logic        o_busy, o_done, o_aborted, o_flag_z, o_flag_c, o_flag_gt;

   int n_chk = 0;
   int n_err = 0;

   alu_sequencer dut (
      .i_clock(clk), .i_reset(i_reset), .i_imem_we(i_imem_we),
      .i_imem_addr(i_imem_addr), .i_imem_wdata(i_imem_wdata),
      .i_instr_count(i_instr_count), .i_start(i_start), .i_rd_sel(i_rd_sel),
      .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done),
      .o_aborted(o_aborted), .o_flag_z(o_flag_z), .o_flag_c(o_flag_c),
      .o_flag_gt(o_flag_gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a, b;
      int         rsel;
      logic [7:0] exp_r;
      logic       exp_z;
      logic       chk_c, exp_c;
      logic       chk_gt, exp_gt;
   } vec_t;

   function automatic vec_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b, int rsel,
                               logic [7:0] r, logic z, logic cc, logic c, logic cg, logic g);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.rsel = rsel; v.exp_r = r; v.exp_z = z;
      v.chk_c = cc; v.exp_c = c; v.chk_gt = cg; v.exp_gt = g;
      return v;
   endfunction

   function automatic logic [17:0] enc(logic [3:0] op, logic [2:0] ra, logic [2:0] rb, logic [7:0] imm);
      return {op, ra, rb, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] addr, input logic [17:0] word);
      @(negedge clk);
      i_imem_we = 1'b1; i_imem_addr = addr; i_imem_wdata = word;
      @(posedge clk); #1;
      i_imem_we = 1'b0;
   endtask

   task automatic rd(input int r, output logic [7:0] v);
      i_rd_sel = r[2:0];
      #1;
      v = o_rd_data;
   endtask

   // Starts a run (optionally with a same-cycle imem write), returns the cycle
   // index of the done pulse and whether busy dropped early, then waits into IDLE.
   task automatic run(input int count, input bit do_wr, input logic [3:0] wa,
                      input logic [17:0] wd, output int cyc, output bit busy_bad);
      @(negedge clk);
      i_instr_count = count[4:0]; i_start = 1'b1;
      if (do_wr) begin i_imem_we = 1'b1; i_imem_addr = wa; i_imem_wdata = wd; end
      @(posedge clk); #1;
      i_start = 1'b0; i_imem_we = 1'b0;
      cyc = 1; busy_bad = 1'b0;
      while (!o_done && cyc < 1000) begin
         if (!o_busy) busy_bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      if (!o_done) begin
         n_chk++; n_err++;
         $display("FAIL run_timeout: no done within %0d cycles", cyc);
      end
      chk("busy_low_at_done", o_busy, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", o_done, 1'b0);
   endtask

   vec_t  vt[20];
   int    cyc;
   bit    bb;
   logic [7:0] v;

   initial begin
      vt[0]  = mk(ADD, 8'h10, 8'h20, 4, 8'h30, 0, 1, 0, 0, 0);
      vt[1]  = mk(ADD, 8'hF0, 8'h20, 4, 8'h10, 0, 1, 1, 0, 0);
      vt[2]  = mk(ADD, 8'h80, 8'h80, 4, 8'h00, 1, 1, 1, 0, 0);
      vt[3]  = mk(SUB, 8'h05, 8'h03, 4, 8'h02, 0, 1, 0, 0, 0);
      vt[4]  = mk(SUB, 8'h03, 8'h05, 4, 8'hFE, 0, 1, 1, 0, 0);
      vt[5]  = mk(INC, 8'hFF, 8'h00, 4, 8'h00, 1, 1, 1, 0, 0);
      vt[6]  = mk(AND, 8'hCC, 8'hAA, 4, 8'h88, 0, 1, 1, 0, 0);
      vt[7]  = mk(INC, 8'h41, 8'h00, 4, 8'h42, 0, 1, 0, 0, 0);
      vt[8]  = mk(OR,  8'hC0, 8'h0C, 4, 8'hCC, 0, 1, 0, 0, 0);
      vt[9]  = mk(XOR, 8'h5A, 8'h5A, 4, 8'h00, 1, 1, 0, 0, 0);
      vt[10] = mk(NOT, 8'h0F, 8'h00, 4, 8'hF0, 0, 1, 0, 0, 0);
      vt[11] = mk(SHR, 8'h81, 8'h00, 4, 8'h40, 0, 1, 1, 0, 0);
      vt[12] = mk(SHL, 8'h81, 8'h00, 4, 8'h02, 0, 1, 1, 0, 0);
      vt[13] = mk(SHL, 8'h40, 8'h00, 4, 8'h80, 0, 1, 0, 0, 0);
      vt[14] = mk(SHR, 8'h01, 8'h00, 4, 8'h00, 1, 1, 1, 0, 0);
      vt[15] = mk(CMP, 8'h07, 8'h03, 4, 8'h07, 0, 1, 1, 1, 1);
      vt[16] = mk(CMP, 8'h03, 8'h07, 4, 8'h03, 0, 1, 1, 1, 0);
      vt[17] = mk(CMP, 8'h09, 8'h09, 4, 8'h09, 1, 1, 1, 1, 0);
      vt[18] = mk(MOV, 8'h33, 8'h00, 5, 8'h33, 1, 1, 1, 1, 0);
      vt[19] = mk(NOP, 8'h12, 8'h34, 4, 8'h12, 0, 1, 1, 1, 0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_aborted", o_aborted, 0);
      chk("rst_flags", {o_flag_z, o_flag_c, o_flag_gt}, 3'b000);
      i_reset = 1'b0;

      // straight line: LDI r0,2; LDI r1,4; ADD r0,r1
      wr(0, enc(LDI, 0, 0, 8'd2));
      wr(1, enc(LDI, 1, 0, 8'd4));
      wr(2, enc(ADD, 0, 1, 8'd0));
      run(3, 0, 0, 0, cyc, bb);
      chk("line_done_cycle", cyc, 7);
      chk("line_busy", bb, 0);
      rd(0, v); chk("line_r0", v, 8'd6);
      rd(1, v); chk("line_r1", v, 8'd4);
      chk("line_z", o_flag_z, 0);

      // empty programme
      run(0, 0, 0, 0, cyc, bb);
      chk("cnt0_done_cycle", cyc, 1);
      rd(0, v); chk("cnt0_r0", v, 8'd6);

      // start and imem_we while busy are ignored
      @(negedge clk);
      i_instr_count = 3; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; cyc = 1;
      while (!o_done && cyc < 100) begin
         if (cyc == 2) begin
            i_start = 1'b1; i_instr_count = 1;
            i_imem_we = 1'b1; i_imem_addr = 0; i_imem_wdata = enc(LDI, 0, 0, 8'h99);
         end
         if (cyc == 4) begin i_start = 1'b0; i_imem_we = 1'b0; i_instr_count = 3; end
         @(posedge clk); #1;
         cyc++;
      end
      chk("busystart_done_cycle", cyc, 7);
      @(posedge clk); #1;
      run(3, 0, 0, 0, cyc, bb);
      rd(0, v); chk("busywe_r0", v, 8'd6);

      // reset in cycle 4 of a run
      @(negedge clk);
      i_instr_count = 3; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      i_reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_done", o_done, 0);
      i_reset = 1'b0;
      for (int r = 0; r < 8; r++) begin
         rd(r, v);
         chk($sformatf("midrst_r%0d", r), v, 8'd0);
      end
      run(3, 0, 0, 0, cyc, bb);
      chk("rerun_done_cycle", cyc, 7);
      rd(0, v); chk("rerun_r0", v, 8'd6);
      rd(1, v); chk("rerun_r1", v, 8'd4);

      // write and start in the same cycle: new word at address 2 is executed
      run(3, 1, 2, enc(SUB, 0, 1, 8'd0), cyc, bb);
      rd(0, v); chk("samecyc_r0", v, 8'hFE);
      chk("samecyc_c", o_flag_c, 1);

      // single-operation table: LDI r4,a; LDI r5,b; op r4,r5
      for (int i = 0; i < 20; i++) begin
         wr(0, enc(LDI, 4, 0, vt[i].a));
         wr(1, enc(LDI, 5, 0, vt[i].b));
         wr(2, enc(vt[i].op, 4, 5, 8'd0));
         run(3, 0, 0, 0, cyc, bb);
         chk($sformatf("vec%0d_cycle", i), cyc, 7);
         rd(vt[i].rsel, v);
         chk($sformatf("vec%0d_res", i), v, vt[i].exp_r);
         chk($sformatf("vec%0d_z", i), o_flag_z, vt[i].exp_z);
         if (vt[i].chk_c)  chk($sformatf("vec%0d_c", i), o_flag_c, vt[i].exp_c);
         if (vt[i].chk_gt) chk($sformatf("vec%0d_gt", i), o_flag_gt, vt[i].exp_gt);
      end

      // SUB with ra==rb
      wr(0, enc(LDI, 2, 0, 8'h77));
      wr(1, enc(SUB, 2, 2, 8'd0));
      run(2, 0, 0, 0, cyc, bb);
      rd(2, v); chk("subself_r2", v, 8'h00);
      chk("subself_z", o_flag_z, 1);
      chk("subself_c", o_flag_c, 0);

      // counted loop: r0 counts to r1 via a CMP/BEQ unconditional back-branch
      wr(0, enc(LDI, 0, 0, 8'd0));
      wr(1, enc(LDI, 1, 0, 8'd3));
      wr(2, enc(INC, 0, 0, 8'd0));
      wr(3, enc(CMP, 0, 1, 8'd0));
      wr(4, enc(BGT, 0, 0, 8'd15));
      wr(5, enc(BEQ, 0, 0, 8'd8));
      wr(6, enc(CMP, 2, 2, 8'd0));
      wr(7, enc(BEQ, 0, 0, 8'd2));
      wr(8, enc(LDI, 3, 0, 8'h55));
      wr(9, enc(HLT, 0, 0, 8'd0));
      run(10, 0, 0, 0, cyc, bb);
      chk("loop_done_cycle", cyc, 41);
      rd(0, v); chk("loop_r0", v, 8'd3);
      rd(3, v); chk("loop_r3", v, 8'h55);
      chk("loop_aborted", o_aborted, 0);

      // taken branch past the instruction count ends the run normally
      wr(0, enc(LDI, 0, 0, 8'd5));
      wr(1, enc(LDI, 1, 0, 8'd2));
      wr(2, enc(CMP, 0, 1, 8'd0));
      wr(3, enc(BGT, 0, 0, 8'd15));
      wr(4, enc(LDI, 0, 0, 8'h11));
      run(5, 0, 0, 0, cyc, bb);
      chk("bfar_done_cycle", cyc, 9);
      rd(0, v); chk("bfar_r0", v, 8'd5);
      chk("bfar_gt", o_flag_gt, 1);
      chk("bfar_aborted", o_aborted, 0);

      // runaway loop hits the step limit
      wr(0, enc(LDI, 0, 0, 8'd0));
      wr(1, enc(CMP, 0, 0, 8'd0));
      wr(2, enc(BEQ, 0, 0, 8'd1));
      run(3, 0, 0, 0, cyc, bb);
      chk("runaway_done_cycle", cyc, 511);
      chk("runaway_aborted", o_aborted, 1);
      run(0, 0, 0, 0, cyc, bb);
      chk("restart_clears_aborted", o_aborted, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
